// File: rtl/tank_reader.sv
// Delay-line tank reader: tracks bit/word position in the recirculating stream and deserialises one word per request.
// Optional macro TANK_READER_SYNC_CHECK_EN: flags a misaligned sync (sticky sync_err) and drops any pending request.
module tank_reader #(
  parameter int WORD_BITS = 17,
  parameter int GAP_BITS  = 1,
  parameter int WORDS     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in,
  input  logic                       sync,
  input  logic                       req_valid,
  input  logic [$clog2(WORDS)-1:0]   req_addr,
  output logic                       req_ready,
  output logic                       rsp_valid,
  output logic [WORD_BITS-1:0]       rsp_data,
  input  logic                       rsp_ready,
  output logic                       sync_err
);
  localparam int SLOT_BITS = WORD_BITS + GAP_BITS;
  localparam int BIT_W     = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam int ADDR_W    = $clog2(WORDS);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SLOT_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_MSB   = BIT_W'(WORD_BITS - 1);
  localparam logic [ADDR_W-1:0] WORD_LAST = ADDR_W'(WORDS - 1);

  typedef enum logic [2:0] {S_UNSYNCED, S_IDLE, S_WAIT, S_SHIFT, S_DONE} state_t;

  state_t               r_state, w_state_next;
  logic [BIT_W-1:0]     r_bit_cnt, w_bit_pos, w_bit_next;
  logic [ADDR_W-1:0]    r_word_cnt, w_word_pos, w_word_next;
  logic [ADDR_W-1:0]    r_addr;
  logic [WORD_BITS-1:0] r_data;
  logic                 r_last, w_last_next;
  logic                 w_cap_start, w_cap_shift;
  logic                 w_sync_bad;
  logic [WORD_BITS-1:0] w_cap_en;

  // A sync edge is position (0,0) regardless of the counters.
  assign w_bit_pos  = sync ? '0 : r_bit_cnt;
  assign w_word_pos = sync ? '0 : r_word_cnt;

  always_comb begin
    w_bit_next  = w_bit_pos + 1'b1;
    w_word_next = w_word_pos;
    if (w_bit_pos == BIT_LAST) begin
      w_bit_next  = '0;
      w_word_next = (w_word_pos == WORD_LAST) ? '0 : w_word_pos + 1'b1;
    end
  end

`ifdef TANK_READER_SYNC_CHECK_EN
  logic r_sync_err;
  assign w_sync_bad = sync && (r_state != S_UNSYNCED) &&
                      ((r_bit_cnt != '0) || (r_word_cnt != '0));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_sync_err <= 1'b0;
    else if (w_sync_bad) r_sync_err <= 1'b1;
  end
  assign sync_err = r_sync_err;
`else
  assign w_sync_bad = 1'b0;
  assign sync_err   = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_cap_start  = 1'b0;
    w_cap_shift  = 1'b0;
    w_last_next  = r_last;
    case (r_state)
      S_UNSYNCED: if (sync) w_state_next = S_IDLE;
      S_IDLE:     if (req_valid) w_state_next = S_WAIT;
      S_WAIT: begin
        if ((w_word_pos == r_addr) && (w_bit_pos == '0)) begin
          w_cap_start  = 1'b1;
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // r_last delays DONE by one edge so rsp_valid rises the edge after the last data bit.
        if (r_last) begin
          w_last_next  = 1'b0;
          w_state_next = S_DONE;
        end else if (sync) begin
          w_state_next = S_WAIT;
        end else begin
          w_cap_shift = 1'b1;
          if (w_bit_pos == BIT_MSB) w_last_next = 1'b1;
        end
      end
      S_DONE:     if (rsp_ready) w_state_next = S_IDLE;
      default:    w_state_next = S_UNSYNCED;
    endcase
    if (w_sync_bad && ((r_state == S_WAIT) || (r_state == S_SHIFT))) begin
      w_state_next = S_IDLE;
      w_cap_start  = 1'b0;
      w_cap_shift  = 1'b0;
      w_last_next  = 1'b0;
    end
  end

  for (genvar gi = 0; gi < WORD_BITS; gi++) begin : g_cap
    if (gi == 0) begin : g_first
      assign w_cap_en[gi] = w_cap_start;
    end else begin : g_rest
      assign w_cap_en[gi] = w_cap_shift && (w_bit_pos == BIT_W'(gi));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_UNSYNCED;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_addr     <= '0;
      r_last     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_bit_cnt  <= w_bit_next;
      r_word_cnt <= w_word_next;
      r_last     <= w_last_next;
      if ((r_state == S_IDLE) && req_valid) r_addr <= req_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else begin
      for (int i = 0; i < WORD_BITS; i++) begin
        if (w_cap_en[i]) r_data[i] <= in;
      end
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_DONE);
  assign rsp_data  = r_data;
endmodule

// File: tb/tb_tank_reader.sv
// Directed bench for tank_reader: drives a modelled 32x18-bit recirculating stream and checks request/response timing.
module tb_tank_reader;
  localparam int WB    = 17;
  localparam int SLOT  = 18;
  localparam int NW    = 32;
  localparam int MAJOR = NW * SLOT;

  logic clk = 1'b0, rst_n = 1'b0, in = 1'b0, sync = 1'b0;
  logic req_valid = 1'b0, rsp_ready = 1'b0;
  logic [4:0] req_addr = '0;
  logic req_ready, rsp_valid, sync_err;
  logic [WB-1:0] rsp_data;

  int checks = 0, failures = 0;
  logic [WB-1:0] mem [NW];
  int cur = 0, nxt = 0, sync_at = -1;

  typedef struct {
    logic [4:0]    addr;
    int            acc;
    logic [WB-1:0] data;
    int            lat;
  } vec_t;
  vec_t vecs [6];

  tank_reader #(.WORD_BITS(WB), .GAP_BITS(1), .WORDS(NW)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .sync(sync),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // Stream model: cur is the position sampled at the coming rising edge; gap bits driven 1.
  always @(negedge clk) begin
    logic [4:0] wi, bi;
    cur  = nxt;
    sync = 1'b0;
    if (sync_at == -2 || (sync_at >= 0 && cur == sync_at)) begin
      cur  = 0;
      sync = 1'b1;
    end
    wi = 5'(cur / SLOT);
    bi = 5'(cur % SLOT);
    in = (cur % SLOT < WB) ? mem[wi][bi] : 1'b1;
    nxt = (cur + 1) % MAJOR;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sync(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < MAJOR + 2 && !seen; i++) begin
      step();
      if (sync) begin
        seen = 1'b1;
        sync_at = -1;
      end
    end
  endtask

  // Counts edges after the acceptance edge until rsp_valid is seen (or the bound expires).
  task automatic wait_rsp(input int bound, output int lat);
    lat = 0;
    while (!rsp_valid && lat < bound) begin
      step();
      lat++;
      if (sync) sync_at = -1;
    end
  endtask

  task automatic accept(input logic [4:0] addr, input int acc, input string tag);
    int n = 0;
    while (nxt != acc && n < 2 * MAJOR) begin
      step();
      n++;
    end
    check({tag, " acc_pos"}, 32'(nxt), 32'(acc));
    req_valid = 1'b1;
    req_addr  = addr;
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic run_req(input vec_t v, input string tag);
    int lat, bad;
    logic [WB-1:0] held;
    mem[v.addr] = v.data;
    accept(v.addr, v.acc, tag);
    wait_rsp(2 * MAJOR, lat);
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " rsp_data"}, 32'(rsp_data), 32'(v.data));
    held = rsp_data;
    bad  = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (!rsp_valid || rsp_data !== held || req_ready) bad++;
    end
    check({tag, " hold_bad"}, 32'(bad), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, " idle_ready"}, 32'(req_ready), 32'd1);
    check({tag, " idle_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int bad, lat;
    bit seen;
    for (int i = 0; i < NW; i++) mem[i] = WB'($urandom);
    // {addr, acceptance position, word, edges from acceptance to rsp_valid}
    vecs[0] = '{5'd5,  36,  17'h1A5A5, 71};
    vecs[1] = '{5'd3,  54,  17'h0ABCD, 593};
    vecs[2] = '{5'd0,  100, 17'h00001, 493};
    vecs[3] = '{5'd31, 575, 17'h10000, 576};
    vecs[4] = '{5'd10, 181, 17'h0F0F0, 592};
    vecs[5] = '{5'd8,  143, 17'h15555, 18};

    repeat (3) step();
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_data",  32'(rsp_data),  32'd0);
    check("rst sync_err",  32'(sync_err),  32'd0);
    rst_n = 1'b1;

    req_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (req_ready || rsp_valid) bad++;
    end
    check("unsynced_bad", 32'(bad), 32'd0);
    req_valid = 1'b0;
    $display("unsynced request: bad_cycles=%0d", bad);

    sync_at = -2;
    wait_sync(seen);
    check("first_sync seen", 32'(seen), 32'd1);
    check("first_sync req_ready", 32'(req_ready), 32'd1);

    for (int k = 0; k < 6; k++) begin
      run_req(vecs[k], $sformatf("vec%0d", k));
      $display("vec%0d addr=%0d acc=%0d data=%05h", k, vecs[k].addr, vecs[k].acc, vecs[k].data);
    end

    // Sync during capture of word 7 at (word 7, bit 4).
    mem[7] = 17'h0C3A5;
    accept(5'd7, 108, "resync");
    sync_at = 130;
`ifdef TANK_READER_SYNC_CHECK_EN
    wait_rsp(700, lat);
    check("resync dropped_valid", 32'(rsp_valid), 32'd0);
    check("resync req_ready", 32'(req_ready), 32'd1);
    check("resync sync_err", 32'(sync_err), 32'd1);
`else
    wait_rsp(2 * MAJOR, lat);
    check("resync latency", 32'(lat), 32'd165);
    check("resync rsp_data", 32'(rsp_data), 32'h0C3A5);
    check("resync sync_err", 32'(sync_err), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("resync idle_ready", 32'(req_ready), 32'd1);
`endif
    $display("resync: lat=%0d sync_err=%0d", lat, sync_err);

    // Reset while shifting word 12.
    mem[12] = 17'h12345;
    accept(5'd12, 214, "rstshift");
    bad = 0;
    while (nxt != 222 && bad < MAJOR) begin
      step();
      bad++;
    end
    rst_n = 1'b0;
    #1;
    check("rstshift rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstshift req_ready", 32'(req_ready), 32'd0);
    check("rstshift rsp_data",  32'(rsp_data),  32'd0);
    check("rstshift sync_err",  32'(sync_err),  32'd0);
    step();
    rst_n = 1'b1;
    req_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (req_ready || rsp_valid) bad++;
    end
    check("rstshift unsynced_bad", 32'(bad), 32'd0);
    req_valid = 1'b0;
    sync_at = -2;
    wait_sync(seen);
    check("rstshift resync_seen", 32'(seen), 32'd1);
    check("rstshift req_ready", 32'(req_ready), 32'd1);
    $display("reset during shift: bad_cycles=%0d", bad);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
